// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issue, hazard and writeback-port control for single-cycle, pipelined FMA
// and iterative divider FP units. The divider path is built only when `FPU_DIV_EN is defined.
module fpu_issue_ctrl #(
   parameter int FMA_LAT = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_class,
   input  logic        req_fwren,
   input  logic [4:0]  req_waddr,
   input  logic [2:0]  req_rden,
   input  logic [4:0]  req_raddr1,
   input  logic [4:0]  req_raddr2,
   input  logic [4:0]  req_raddr3,
   input  logic        flush,
   output logic        fma_start,
   output logic        div_start,
   output logic        div_kill,
   input  logic        div_done,
   output logic        wb_valid,
   output logic [1:0]  wb_sel,
   output logic        wb_fwren,
   output logic [4:0]  wb_waddr,
   output logic        req_illegal,
   output logic [31:0] pending,
   output logic        busy
);

   localparam logic [1:0] CLS_SC  = 2'd0;
   localparam logic [1:0] CLS_FMA = 2'd1;
   localparam logic [1:0] CLS_DIV = 2'd2;
   localparam logic [1:0] CLS_ILL = 2'd3;
   localparam logic [1:0] SEL_SC  = 2'd0;
   localparam logic [1:0] SEL_FMA = 2'd1;
   localparam logic [1:0] SEL_DIV = 2'd2;
`ifdef FPU_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic [31:0]             pending_q, pending_d;
   logic [FMA_LAT-1:0]      fma_vld_q, fma_vld_d;
   logic [FMA_LAT-1:0][4:0] fma_waddr_q;
   logic [FMA_LAT-1:0]      fma_fwren_q;

   logic       hazard, class_ok, accept;
   logic       acc_sc, acc_fma, acc_div;
   logic       fma_ret;
   logic       div_idle, div_wb, div_fw;
   logic [4:0] div_wa;

   assign fma_ret = fma_vld_q[FMA_LAT-1];

   // No bypass: a register retiring this cycle still blocks its readers and writers.
   assign hazard = (req_rden[0] && pending_q[req_raddr1]) ||
                   (req_rden[1] && pending_q[req_raddr2]) ||
                   (req_rden[2] && pending_q[req_raddr3]) ||
                   (req_fwren   && pending_q[req_waddr]);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      class_ok = 1'b1;
      case (req_class)
         CLS_SC:  class_ok = !fma_ret && !div_wb;
         CLS_DIV: class_ok = div_idle;
         default: class_ok = 1'b1;
      endcase
   end

   assign req_ready   = reset && !flush && !hazard && class_ok;
   assign accept      = req_valid && req_ready;
   assign acc_sc      = accept && (req_class == CLS_SC);
   assign acc_fma     = accept && (req_class == CLS_FMA);
   assign acc_div     = accept && (req_class == CLS_DIV) && DIV_EN;
   assign req_illegal = accept && ((req_class == CLS_ILL) || ((req_class == CLS_DIV) && !DIV_EN));
   assign fma_start   = acc_fma;
   assign busy        = (|fma_vld_q) || !div_idle;
   assign pending     = pending_q;

   always_comb begin
      fma_vld_d = '0;
      if (!flush) begin
         fma_vld_d[0] = acc_fma;
         for (int i = 1; i < FMA_LAT; i++) fma_vld_d[i] = fma_vld_q[i-1];
      end
   end

   // NOTE: payload flops carry no reset; the valid bits alone decide whether they are used.
   always_ff @(posedge clock) begin
      fma_waddr_q[0] <= req_waddr;
      fma_fwren_q[0] <= req_fwren;
      for (int i = 1; i < FMA_LAT; i++) begin
         fma_waddr_q[i] <= fma_waddr_q[i-1];
         fma_fwren_q[i] <= fma_fwren_q[i-1];
      end
   end

`ifdef FPU_DIV_EN
   typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_HOLD} div_state_e;

   div_state_e div_state_q, div_state_d;
   logic [4:0] div_waddr_q, div_waddr_d;
   logic       div_fwren_q, div_fwren_d;

   assign div_idle  = (div_state_q == DIV_IDLE);
   assign div_wb    = !fma_ret && ((div_state_q == DIV_HOLD) ||
                                   ((div_state_q == DIV_BUSY) && div_done));
   assign div_wa    = div_waddr_q;
   assign div_fw    = div_fwren_q;
   assign div_start = acc_div;
   assign div_kill  = flush && !div_idle;

   always_comb begin
      div_state_d = div_state_q;
      div_waddr_d = div_waddr_q;
      div_fwren_d = div_fwren_q;
      if (flush) begin
         div_state_d = DIV_IDLE;
      end else begin
         case (div_state_q)
            DIV_IDLE: if (acc_div) begin
               div_state_d = DIV_BUSY;
               div_waddr_d = req_waddr;
               div_fwren_d = req_fwren;
            end
            DIV_BUSY: if (div_done) div_state_d = fma_ret ? DIV_HOLD : DIV_IDLE;
            DIV_HOLD: if (!fma_ret) div_state_d = DIV_IDLE;
            default:  div_state_d = DIV_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         div_state_q <= DIV_IDLE;
         div_waddr_q <= '0;
         div_fwren_q <= 1'b0;
      end else begin
         div_state_q <= div_state_d;
         div_waddr_q <= div_waddr_d;
         div_fwren_q <= div_fwren_d;
      end
   end
`else
   logic unused_div_done;
   assign unused_div_done = div_done;
   assign div_idle  = 1'b1;
   assign div_wb    = 1'b0;
   assign div_wa    = '0;
   assign div_fw    = 1'b0;
   assign div_start = 1'b0;
   assign div_kill  = 1'b0;
`endif

   always_comb begin
      wb_valid = 1'b0;
      wb_sel   = SEL_SC;
      wb_fwren = 1'b0;
      wb_waddr = '0;
      if (!flush) begin
         if (fma_ret) begin
            wb_valid = 1'b1;
            wb_sel   = SEL_FMA;
            wb_fwren = fma_fwren_q[FMA_LAT-1];
            wb_waddr = fma_waddr_q[FMA_LAT-1];
         end else if (div_wb) begin
            wb_valid = 1'b1;
            wb_sel   = SEL_DIV;
            wb_fwren = div_fw;
            wb_waddr = div_wa;
         end else if (acc_sc) begin
            wb_valid = 1'b1;
            wb_sel   = SEL_SC;
            wb_fwren = req_fwren;
            wb_waddr = req_waddr;
         end
      end
   end

   always_comb begin
      pending_d = pending_q;
      if (flush) begin
         pending_d = '0;
      end else begin
         if (fma_ret && fma_fwren_q[FMA_LAT-1]) pending_d[fma_waddr_q[FMA_LAT-1]] = 1'b0;
         if (div_wb && div_fw) pending_d[div_wa] = 1'b0;
         if ((acc_fma || acc_div) && req_fwren) pending_d[req_waddr] = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
         fma_vld_q <= '0;
         pending_q <= '0;
      end else begin
         fma_vld_q <= fma_vld_d;
         pending_q <= pending_d;
      end
   end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed scenarios plus randomized traffic checked against a
// cycle-level behavioural model of the issue rules (honours `FPU_DIV_EN like the DUT).
module tb_fpu_issue_ctrl;
   localparam int LAT = 3;
`ifdef FPU_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   typedef struct {
      int         ret;
      logic [4:0] wa;
      logic       fw;
   } fma_op_t;

   logic        clock, reset, req_valid, req_ready, req_fwren, flush;
   logic [1:0]  req_class, wb_sel;
   logic [4:0]  req_waddr, req_raddr1, req_raddr2, req_raddr3, wb_waddr;
   logic [2:0]  req_rden;
   logic        fma_start, div_start, div_kill, div_done, wb_valid, wb_fwren, req_illegal, busy;
   logic [31:0] pending;
   int          n_chk = 0;
   int          n_fail = 0;

   fpu_issue_ctrl #(.FMA_LAT(LAT)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_class(req_class), .req_fwren(req_fwren), .req_waddr(req_waddr), .req_rden(req_rden),
      .req_raddr1(req_raddr1), .req_raddr2(req_raddr2), .req_raddr3(req_raddr3), .flush(flush),
      .fma_start(fma_start), .div_start(div_start), .div_kill(div_kill), .div_done(div_done),
      .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_fwren(wb_fwren), .wb_waddr(wb_waddr),
      .req_illegal(req_illegal), .pending(pending), .busy(busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish by 500000, want finish earlier");
      $fatal(1, "watchdog expired");
   end

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic idle_in;
      req_valid = 0; req_class = 0; req_fwren = 0; req_waddr = 0; req_rden = 0;
      req_raddr1 = 0; req_raddr2 = 0; req_raddr3 = 0; flush = 0; div_done = 0;
   endtask

   task automatic offer(input logic [1:0] cls, input logic [4:0] wa, input logic fw,
                        input logic [2:0] rd, input logic [4:0] r1);
      idle_in();
      req_valid = 1; req_class = cls; req_waddr = wa; req_fwren = fw; req_rden = rd; req_raddr1 = r1;
   endtask

   task automatic settle;
      idle_in();
      repeat (8) step();
   endtask

   task automatic test_reset;
      reset = 0;
      offer(2'd0, 5'd1, 1'b1, 3'b000, 5'd0);
      #12;
      n_chk++; if (req_ready !== 1'b0) begin $display("FAIL reset_ready: got %b want 0", req_ready); n_fail++; end
      n_chk++; if (wb_valid !== 1'b0) begin $display("FAIL reset_wb_valid: got %b want 0", wb_valid); n_fail++; end
      n_chk++; if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); n_fail++; end
      n_chk++; if (pending !== 32'h0) begin $display("FAIL reset_pending: got %h want 0", pending); n_fail++; end
      n_chk++; if ({fma_start, div_start, div_kill, req_illegal} !== 4'b0000) begin
         $display("FAIL reset_pulses: got %b want 0000", {fma_start, div_start, div_kill, req_illegal}); n_fail++; end
      @(posedge clock); #1;
      reset = 1;
      settle();
   endtask

   task automatic test_fma_basic;
      offer(2'd1, 5'd5, 1'b1, 3'b000, 5'd0);
      #1;
      n_chk++; if ({req_ready, fma_start} !== 2'b11) begin $display("FAIL fma_issue: got %b want 11", {req_ready, fma_start}); n_fail++; end
      step(); idle_in();
      for (int c = 1; c <= 4; c++) begin
         #1;
         n_chk++; if (pending[5] !== (c <= 3)) begin $display("FAIL fma_pending c%0d: got %b want %b", c, pending[5], c <= 3); n_fail++; end
         n_chk++; if (wb_valid !== (c == 3)) begin $display("FAIL fma_wb_valid c%0d: got %b want %b", c, wb_valid, c == 3); n_fail++; end
         if (c == 3) begin
            n_chk++; if ({wb_sel, wb_waddr, wb_fwren} !== {2'd1, 5'd5, 1'b1}) begin
               $display("FAIL fma_wb_fields: got sel %0d waddr %0d fw %b want sel 1 waddr 5 fw 1", wb_sel, wb_waddr, wb_fwren); n_fail++; end
         end
         step();
      end
      settle();
   endtask

   task automatic test_raw_hazard;
      offer(2'd1, 5'd5, 1'b1, 3'b000, 5'd0);
      step();
      for (int c = 1; c <= 4; c++) begin
         offer(2'd0, 5'd9, 1'b1, 3'b001, 5'd5);
         #1;
         n_chk++; if (req_ready !== (c == 4)) begin $display("FAIL raw_ready c%0d: got %b want %b", c, req_ready, c == 4); n_fail++; end
         if (c == 4) begin
            n_chk++; if ({wb_valid, wb_sel, wb_waddr} !== {1'b1, 2'd0, 5'd9}) begin
               $display("FAIL raw_sc_wb: got v %b sel %0d waddr %0d want v 1 sel 0 waddr 9", wb_valid, wb_sel, wb_waddr); n_fail++; end
         end
         step();
      end
      settle();
   endtask

   task automatic test_sc_conflict;
      offer(2'd1, 5'd3, 1'b1, 3'b000, 5'd0);
      step(); idle_in();
      repeat (2) step();
      offer(2'd0, 5'd10, 1'b1, 3'b000, 5'd0);
      #1;
      n_chk++; if ({req_ready, wb_valid, wb_sel, wb_waddr} !== {1'b0, 1'b1, 2'd1, 5'd3}) begin
         $display("FAIL conflict_retire: got rdy %b v %b sel %0d wa %0d want rdy 0 v 1 sel 1 wa 3", req_ready, wb_valid, wb_sel, wb_waddr); n_fail++; end
      step();
      #1;
      n_chk++; if ({req_ready, wb_valid, wb_sel, wb_waddr, wb_fwren} !== {1'b1, 1'b1, 2'd0, 5'd10, 1'b1}) begin
         $display("FAIL conflict_next: got rdy %b v %b sel %0d wa %0d want rdy 1 v 1 sel 0 wa 10", req_ready, wb_valid, wb_sel, wb_waddr); n_fail++; end
      settle();
   endtask

   task automatic test_back_to_back;
      for (int c = 0; c < 8; c++) begin
         if (c < 4) offer(2'd1, 5'(c + 1), 1'b1, 3'b000, 5'd0);
         else idle_in();
         #1;
         n_chk++; if (fma_start !== (c < 4)) begin $display("FAIL b2b_start c%0d: got %b want %b", c, fma_start, c < 4); n_fail++; end
         n_chk++; if (wb_valid !== (c >= 3 && c <= 6)) begin $display("FAIL b2b_wb c%0d: got %b want %b", c, wb_valid, c >= 3 && c <= 6); n_fail++; end
         if (c >= 3 && c <= 6) begin
            n_chk++; if (wb_waddr !== 5'(c - 2)) begin $display("FAIL b2b_waddr c%0d: got %0d want %0d", c, wb_waddr, c - 2); n_fail++; end
         end
         step();
      end
      settle();
   endtask

`ifdef FPU_DIV_EN
   task automatic test_div_hold;
      offer(2'd2, 5'd7, 1'b1, 3'b000, 5'd0);
      #1;
      n_chk++; if ({req_ready, div_start} !== 2'b11) begin $display("FAIL div_issue: got %b want 11", {req_ready, div_start}); n_fail++; end
      step(); idle_in();
      #1;
      n_chk++; if ({busy, pending[7]} !== 2'b11) begin $display("FAIL div_busy: got %b want 11", {busy, pending[7]}); n_fail++; end
      step();
      offer(2'd1, 5'd2, 1'b1, 3'b000, 5'd0);
      #1;
      n_chk++; if ({req_ready, fma_start} !== 2'b11) begin $display("FAIL div_fma_issue: got %b want 11", {req_ready, fma_start}); n_fail++; end
      step(); idle_in();
      repeat (2) step();
      div_done = 1;
      #1;
      n_chk++; if ({wb_valid, wb_sel, wb_waddr} !== {1'b1, 2'd1, 5'd2}) begin
         $display("FAIL div_hold_fma_wb: got v %b sel %0d wa %0d want v 1 sel 1 wa 2", wb_valid, wb_sel, wb_waddr); n_fail++; end
      step();
      offer(2'd2, 5'd8, 1'b0, 3'b000, 5'd0);
      #1;
      n_chk++; if ({req_ready, wb_valid, wb_sel, wb_waddr} !== {1'b0, 1'b1, 2'd2, 5'd7}) begin
         $display("FAIL div_hold_wb: got rdy %b v %b sel %0d wa %0d want rdy 0 v 1 sel 2 wa 7", req_ready, wb_valid, wb_sel, wb_waddr); n_fail++; end
      step(); idle_in();
      #1;
      n_chk++; if ({busy, pending} !== 33'h0) begin $display("FAIL div_hold_drain: got busy %b pend %h want 0 0", busy, pending); n_fail++; end
      settle();
   endtask

   task automatic test_div_flush;
      offer(2'd2, 5'd7, 1'b1, 3'b000, 5'd0);
      step();
      offer(2'd1, 5'd4, 1'b1, 3'b000, 5'd0);
      step();
      offer(2'd1, 5'd11, 1'b1, 3'b000, 5'd0);
      flush = 1;
      #1;
      n_chk++; if ({div_kill, wb_valid, req_ready, fma_start} !== 4'b1000) begin
         $display("FAIL flush_cycle: got %b want 1000", {div_kill, wb_valid, req_ready, fma_start}); n_fail++; end
      step(); idle_in();
      #1;
      n_chk++; if ({busy, div_kill, pending} !== 34'h0) begin $display("FAIL flush_after: got busy %b kill %b pend %h want 0", busy, div_kill, pending); n_fail++; end
      for (int c = 0; c < 3; c++) begin
         step(); #1;
         n_chk++; if (wb_valid !== 1'b0) begin $display("FAIL flush_no_wb c%0d: got %b want 0", c, wb_valid); n_fail++; end
      end
      settle();
   endtask
`endif

   task automatic test_illegal;
      logic [1:0] cls[$];
      cls.push_back(2'd3);
`ifndef FPU_DIV_EN
      cls.push_back(2'd2);
`endif
      foreach (cls[k]) begin
         offer(cls[k], 5'd6, 1'b1, 3'b000, 5'd0);
         #1;
         n_chk++; if ({req_ready, req_illegal, fma_start, div_start, wb_valid} !== 5'b11000) begin
            $display("FAIL illegal_cls%0d: got %b want 11000", cls[k], {req_ready, req_illegal, fma_start, div_start, wb_valid}); n_fail++; end
         step(); idle_in();
         #1;
         n_chk++; if ({req_illegal, busy, pending} !== 34'h0) begin $display("FAIL illegal_after_cls%0d: got ill %b busy %b pend %h want 0", cls[k], req_illegal, busy, pending); n_fail++; end
         settle();
      end
   endtask

   task automatic test_reset_mid;
      offer(2'd1, 5'd12, 1'b1, 3'b000, 5'd0);
      step();
      offer(2'd2, 5'd13, 1'b1, 3'b000, 5'd0);
      step(); idle_in();
      reset = 0;
      flush = 1;
      #1;
      n_chk++; if ({busy, div_kill, wb_valid, pending} !== 35'h0) begin
         $display("FAIL reset_mid: got busy %b kill %b v %b pend %h want 0", busy, div_kill, wb_valid, pending); n_fail++; end
      step();
      reset = 1; idle_in();
      #1;
      n_chk++; if (wb_valid !== 1'b0) begin $display("FAIL reset_mid_no_wb: got %b want 0", wb_valid); n_fail++; end
      settle();
   endtask

   task automatic test_random(input int n);
      fma_op_t     fq[$];
      logic [31:0] mp = '0;
      bit          d_act = 0, d_held = 0;
      logic [4:0]  d_wa = '0;
      logic        d_fw = 1'b0;
      bit          f_ret, d_wb, haz, c_ok, rdy, acc, e_wb;
      logic [1:0]  e_sel;
      logic [4:0]  e_wa;
      logic        e_fw;
      logic [3:0]  e_pulse;
      idle_in(); flush = 1;
      step(); idle_in();
      step();
      for (int c = 0; c < n; c++) begin
         req_valid = ($urandom_range(3) != 0);
         req_class = 2'($urandom);
         req_fwren = 1'($urandom);
         req_waddr = 5'($urandom_range(7));
         req_rden = 3'($urandom);
         req_raddr1 = 5'($urandom_range(7));
         req_raddr2 = 5'($urandom_range(7));
         req_raddr3 = 5'($urandom_range(7));
         flush = ($urandom_range(31) == 0);
         div_done = ($urandom_range(5) == 0);
         #1;
         f_ret = (fq.size() != 0) && (fq[0].ret == c);
         d_wb = d_act && (d_held || div_done) && !f_ret;
         haz = (req_rden[0] && mp[req_raddr1]) || (req_rden[1] && mp[req_raddr2]) ||
               (req_rden[2] && mp[req_raddr3]) || (req_fwren && mp[req_waddr]);
         case (req_class)
            2'd0: c_ok = !f_ret && !d_wb;
            2'd2: c_ok = !d_act;
            default: c_ok = 1;
         endcase
         rdy = !flush && !haz && c_ok;
         acc = req_valid && rdy;
         e_wb = 0; e_sel = 0; e_wa = 0; e_fw = 0;
         if (!flush) begin
            if (f_ret) begin e_wb = 1; e_sel = 1; e_wa = fq[0].wa; e_fw = fq[0].fw; end
            else if (d_wb) begin e_wb = 1; e_sel = 2; e_wa = d_wa; e_fw = d_fw; end
            else if (acc && req_class == 2'd0) begin e_wb = 1; e_sel = 0; e_wa = req_waddr; e_fw = req_fwren; end
         end
         e_pulse = {acc && req_class == 2'd1, acc && req_class == 2'd2 && DIV_EN, flush && d_act,
                    acc && (req_class == 2'd3 || (req_class == 2'd2 && !DIV_EN))};
         n_chk++; if (req_ready !== rdy) begin $display("FAIL rnd_ready c%0d: got %b want %b", c, req_ready, rdy); n_fail++; end
         n_chk++; if (wb_valid !== e_wb) begin $display("FAIL rnd_wb_valid c%0d: got %b want %b", c, wb_valid, e_wb); n_fail++; end
         if (e_wb) begin
            n_chk++; if ({wb_sel, wb_waddr, wb_fwren} !== {e_sel, e_wa, e_fw}) begin
               $display("FAIL rnd_wb_fields c%0d: got sel %0d wa %0d fw %b want sel %0d wa %0d fw %b", c, wb_sel, wb_waddr, wb_fwren, e_sel, e_wa, e_fw); n_fail++; end
         end
         n_chk++; if ({fma_start, div_start, div_kill, req_illegal} !== e_pulse) begin
            $display("FAIL rnd_pulses c%0d: got %b want %b", c, {fma_start, div_start, div_kill, req_illegal}, e_pulse); n_fail++; end
         n_chk++; if (pending !== mp) begin $display("FAIL rnd_pending c%0d: got %h want %h", c, pending, mp); n_fail++; end
         n_chk++; if (busy !== ((fq.size() != 0) || d_act)) begin $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, (fq.size() != 0) || d_act); n_fail++; end
         if (flush) begin
            fq.delete(); mp = '0; d_act = 0; d_held = 0;
         end else begin
            if (f_ret) begin
               if (fq[0].fw) mp[fq[0].wa] = 1'b0;
               void'(fq.pop_front());
            end
            if (d_wb) begin
               if (d_fw) mp[d_wa] = 1'b0;
               d_act = 0; d_held = 0;
            end else if (d_act && div_done) begin
               d_held = 1;
            end
            if (acc && req_class == 2'd1) begin
               fq.push_back('{ret: c + LAT, wa: req_waddr, fw: req_fwren});
               if (req_fwren) mp[req_waddr] = 1'b1;
            end
            if (acc && req_class == 2'd2 && DIV_EN) begin
               d_act = 1; d_held = 0; d_wa = req_waddr; d_fw = req_fwren;
               if (req_fwren) mp[req_waddr] = 1'b1;
            end
         end
         step();
      end
      settle();
   endtask

   initial begin
      idle_in();
      test_reset();
      test_fma_basic();
      test_raw_hazard();
      test_sc_conflict();
      test_back_to_back();
`ifdef FPU_DIV_EN
      test_div_hold();
      test_div_flush();
`endif
      test_illegal();
      test_reset_mid();
      test_random(1500);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL have parameter FMA_LAT, default 3, fixed FMA pipeline latency in cycles (legal range 1..8).
REQ-002 SHALL have ports (name, direction, width, meaning):
- clock, in, 1: single clock; all state on rising edge.
- reset, in, 1: asynchronous, active-low reset.
- req_valid, in, 1: FP op offered.
- req_ready, out, 1: op accepted this cycle when req_valid=1.
- req_class, in, 2: 0 single-cycle, 1 FMA/add/mul, 2 div/sqrt, 3 reserved.
- req_fwren, in, 1: destination is an FP register.
- req_waddr, in, 5: destination register.
- req_rden, in, 3: source enables for sources 1..3.
- req_raddr1, req_raddr2, req_raddr3, in, 5 each: source registers.
- flush, in, 1: kill all in-flight ops.
- fma_start, out, 1: pulse that launches the FMA pipeline.
- div_start, out, 1: pulse that launches the divider.
- div_kill, out, 1: pulse that aborts the divider.
- div_done, in, 1: divider result valid (one cycle).
- wb_valid, out, 1: writeback-port strobe.
- wb_sel, out, 2: 0 single-cycle, 1 FMA, 2 divider.
- wb_fwren, out, 1: FP-register write.
- wb_waddr, out, 5: writeback destination.
- req_illegal, out, 1: pulse when an op is rejected as illegal.
- pending, out, 32: FP destinations awaiting writeback.
- busy, out, 1: any op in flight.

Function
REQ-003 SHALL transfer a request only when req_valid=1 and req_ready=1; req_ready SHALL be combinational.
REQ-004 SHALL hold req_ready=0 when flush=1.
REQ-005 SHALL hold req_ready=0 on a hazard: any enabled source, or req_waddr with req_fwren=1, has its pending bit set. A register retiring in the current cycle still counts as pending; there is no bypass.
REQ-006 SHALL give the writeback port fixed priority: FMA retire, then held divider result, then single-cycle op.
REQ-007 Class 0 SHALL be ready only when neither higher-priority source uses the port this cycle; on acceptance it SHALL write back in the same cycle (wb_sel=0) and SHALL set no pending bit.
REQ-008 Class 1 SHALL be ready whenever there is no hazard. Acceptance SHALL pulse fma_start and push {waddr, fwren} into a FMA_LAT-stage shift register. It SHALL write back exactly FMA_LAT cycles later with wb_sel=1. Back-to-back issue SHALL be supported, one op per cycle.
REQ-009 The divider FSM SHALL have states IDLE, BUSY and HOLD. Class 2 SHALL be ready only in IDLE.
- IDLE -> BUSY on accept, with a div_start pulse.
- BUSY -> IDLE on div_done when no FMA retire is present, writing back that cycle with wb_sel=2.
- BUSY -> HOLD on div_done when an FMA retire is present; the result is captured.
- HOLD -> IDLE in the first cycle without an FMA retire, writing back that cycle.
REQ-010 Class 3 SHALL be accepted, SHALL pulse req_illegal for one cycle, and SHALL produce no start and no writeback.
REQ-011 pending[waddr] SHALL be set at acceptance when fwren=1 and the class is 1 or 2. It SHALL clear at the clock edge ending that op's writeback cycle.
REQ-012 On flush, the controller SHALL clear all FMA stages and pending bits and force the divider FSM to IDLE. It SHALL pulse div_kill if the FSM was BUSY or HOLD. wb_valid SHALL be 0 in the flush cycle.
REQ-013 div_done received while the FSM is IDLE SHALL be ignored.
REQ-014 busy SHALL be 1 when any FMA stage is valid or the divider FSM is not IDLE.

Reset
REQ-015 While reset=0, asynchronously: FMA stages invalid, divider FSM IDLE, pending=0, captured result cleared.
REQ-016 While reset=0: all pulse outputs 0, wb_valid=0, busy=0, req_ready=0.
REQ-017 Reset asserted mid-operation SHALL discard all in-flight ops without a div_kill pulse.

Configuration
REQ-018 With macro FPU_DIV_EN defined, class 2 SHALL behave per REQ-009.
REQ-019 Without FPU_DIV_EN, class 2 SHALL be treated as class 3 (REQ-010), div_start and div_kill SHALL be tied to 0, div_done SHALL be ignored, and no divider FSM SHALL be built.

Verification
REQ-020 The bench SHALL cover these scenarios with FMA_LAT=3:
- FMA f5 accepted at cycle 0 -> fma_start at 0, pending[5]=1 during cycles 1-3, wb_valid/wb_sel=1/wb_waddr=5 at cycle 3, pending[5]=0 at cycle 4.
- FMA f5 at cycle 0, then class-0 op reading f5 -> req_ready=0 for cycles 0-3, accepted at cycle 4.
- Divider op f7 at cycle 0, FMA f2 at cycle 2, div_done at cycle 5 -> wb f2 (sel 1) at cycle 5, FSM in HOLD, wb f7 (sel 2) at cycle 6.
- Class-0 op offered in a cycle with an FMA retire -> req_ready=0, accepted the next cycle with wb_sel=0.
- Divider BUSY, flush=1 -> div_kill pulse, pending=0, busy=0 next cycle, no writeback.
- Class 3, or class 2 without FPU_DIV_EN -> one req_illegal pulse, no start, no wb_valid.
